// File: rtl/cdc_pkg.sv
// cdc_pkg
// Shared types and constants for the clock-domain-crossing handshake arbiter.
//   state_t    : handshake FSM state encoding (IDLE, REQ_HI, ACK_WAIT_LO)
//   XFER_CNT_W : width of the completed-transfer counter
package cdc_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    REQ_HI      = 2'd1,
    ACK_WAIT_LO = 2'd2
  } state_t;

  localparam int XFER_CNT_W = 16;

endpackage

// File: rtl/cdc_rr_arbiter.sv
// cdc_rr_arbiter
// Combinational round-robin selector. The search starts one position after
// the last winner and wraps, so the last winner has the lowest priority.
// Ports:
//   req        in  NUM_REQ         request vector
//   last_grant in  $clog2(NUM_REQ) index of the previous winner
//   grant      out NUM_REQ         one-hot winner (all zero when no request)
//   grant_idx  out $clog2(NUM_REQ) index of the winner (last_grant when idle)
module cdc_rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last_grant,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] cand;
  logic             found;

  always_comb begin
    grant     = '0;
    grant_idx = last_grant;
    found     = 1'b0;
    cand      = '0;
    // Offsets 1..NUM_REQ visit every requester once, ending at last_grant.
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(last_grant) + k) % NUM_REQ);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/cdc_hs_arbiter.sv
// cdc_hs_arbiter
// Arbitrates NUM_REQ source requesters onto a single 4-phase req/ack link
// toward another clock domain. The acknowledge is synchronized before use.
// Ports:
//   clock        in  1                single clock, rising edge
//   srst         in  1                synchronous active-high reset
//   in_valid     in  NUM_REQ          per-requester valid
//   in_data      in  NUM_REQ*DATA_W   payloads, requester i at [i*DATA_W +: DATA_W]
//   in_ready     out NUM_REQ          one-hot, one-cycle acceptance pulse
//   tx_req       out 1                4-phase request
//   tx_data      out DATA_W           payload held for the destination
//   tx_ack_async in  1                4-phase acknowledge (asynchronous)
//   busy         out 1                FSM not in IDLE
//   grant_id     out $clog2(NUM_REQ)  index of the last accepted requester
//   err_clr      in  1                clears timeout_err
//   timeout_err  out 1                sticky phase-timeout flag
//   xfer_cnt     out 16               completed transfers (wraps)
//   state_dbg    out state_t          current FSM state
//
// Source-side handshake: a requester raises in_valid with its payload and
// holds both until it sees in_ready[i] high for one cycle; that cycle is the
// transfer. Dropping in_valid before in_ready simply withdraws the request.
// in_valid is only looked at while the FSM is IDLE.
module cdc_hs_arbiter
  import cdc_pkg::*;
#(
  parameter int NUM_REQ = 4,    // 2..8
  parameter int DATA_W  = 8,
  parameter int STAGES  = 2,    // >= 2
  parameter int TIMEOUT = 1023  // >= 1
) (
  input  logic                          clock,
  input  logic                          srst,
  input  logic [NUM_REQ-1:0]            in_valid,
  input  logic [NUM_REQ*DATA_W-1:0]     in_data,
  output logic [NUM_REQ-1:0]            in_ready,
  output logic                          tx_req,
  output logic [DATA_W-1:0]             tx_data,
  input  logic                          tx_ack_async,
  output logic                          busy,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  input  logic                          err_clr,
  output logic                          timeout_err,
  output logic [XFER_CNT_W-1:0]         xfer_cnt,
  output state_t                        state_dbg
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(TIMEOUT);
  // The timer reaches TIMEOUT on the edge where it leaves TIMEOUT-1.
  localparam logic [TMR_W-1:0] TMR_FIRE = TMR_W'(TIMEOUT - 1);

  state_t                  state;
  logic [STAGES-1:0]       ack_sync;
  logic                    ack_s;
  logic [TMR_W-1:0]        timer;
  logic [XFER_CNT_W-1:0]   xfer_cnt_q;
  logic [NUM_REQ-1:0]      arb_grant;
  logic [IDX_W-1:0]        arb_idx;
  logic [DATA_W-1:0]       pick_data;
  logic                    in_wait;
  logic                    tmo_event;

  // Ack synchronizer; only the last stage is used anywhere.
  always_ff @(posedge clock) begin
    if (srst) ack_sync <= '0;
    else      ack_sync <= {ack_sync[STAGES-2:0], tx_ack_async};
  end
  assign ack_s = ack_sync[STAGES-1];

  cdc_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req        (in_valid),
    .last_grant (grant_id),
    .grant      (arb_grant),
    .grant_idx  (arb_idx)
  );

  assign pick_data = in_data[int'(arb_idx) * DATA_W +: DATA_W];
  assign in_wait   = (state == REQ_HI) || (state == ACK_WAIT_LO);
  assign tmo_event = in_wait && (timer == TMR_FIRE);

  always_ff @(posedge clock) begin
    if (srst) begin
      state       <= IDLE;
      in_ready    <= '0;
      tx_req      <= 1'b0;
      tx_data     <= '0;
      grant_id    <= IDX_W'(NUM_REQ - 1);
      timer       <= '0;
      timeout_err <= 1'b0;
      xfer_cnt_q  <= '0;
    end else begin
      in_ready <= '0;
      // tx_req follows the state one cycle late: it rises the cycle after
      // the in_ready pulse and falls the cycle after leaving REQ_HI.
      tx_req   <= (state == REQ_HI);

      // Set beats clear when both happen together.
      if (tmo_event)    timeout_err <= 1'b1;
      else if (err_clr) timeout_err <= 1'b0;

      if (in_wait && (timer != TMR_MAX)) timer <= timer + 1'b1;

      case (state)
        IDLE: begin
          // A stale ack still high from a previous link state holds off grants.
          if (!ack_s && (|in_valid)) begin
            in_ready <= arb_grant;
            tx_data  <= pick_data;
            grant_id <= arb_idx;
            timer    <= '0;
            state    <= REQ_HI;
          end
        end
        REQ_HI: begin
          if (ack_s) begin
            timer <= '0;
            state <= ACK_WAIT_LO;
          end
        end
        ACK_WAIT_LO: begin
          if (!ack_s) begin
            xfer_cnt_q <= xfer_cnt_q + 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign xfer_cnt  = xfer_cnt_q;
  assign state_dbg = state;

endmodule

// File: tb/tb_cdc_hs_arbiter.sv
// tb_cdc_hs_arbiter
// Bench for cdc_hs_arbiter (NUM_REQ=4, DATA_W=8, STAGES=2, TIMEOUT=15):
// reset checks, a table of single transfers, round-robin ordering, a random
// run against a round-robin reference model, counter wrap, timeout, reset
// mid-transfer and stale-ack blocking.
module tb_cdc_hs_arbiter;
  import cdc_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 8;
  localparam int STAGES  = 2;
  localparam int TIMEOUT = 15;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic                       srst;
  logic [NUM_REQ-1:0]         in_valid;
  logic [NUM_REQ*DATA_W-1:0]  in_data;
  logic [NUM_REQ-1:0]         in_ready;
  logic                       tx_req;
  logic [DATA_W-1:0]          tx_data;
  logic                       tx_ack_async;
  logic                       busy;
  logic [1:0]                 grant_id;
  logic                       err_clr;
  logic                       timeout_err;
  logic [15:0]                xfer_cnt;
  state_t                     state_dbg;

  logic man_ack;
  logic resp_ack;
  logic auto_ack;
  int   resp_cnt;
  int   resp_max;

  assign tx_ack_async = auto_ack ? resp_ack : man_ack;

  cdc_hs_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .STAGES(STAGES), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock        (clock),
    .srst         (srst),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .tx_req       (tx_req),
    .tx_data      (tx_data),
    .tx_ack_async (tx_ack_async),
    .busy         (busy),
    .grant_id     (grant_id),
    .err_clr      (err_clr),
    .timeout_err  (timeout_err),
    .xfer_cnt     (xfer_cnt),
    .state_dbg    (state_dbg)
  );

  // Destination-domain responder: follows tx_req with a random delay.
  always @(posedge clock) begin
    if (!auto_ack) begin
      resp_ack <= 1'b0;
      resp_cnt <= 0;
    end else if (resp_ack == tx_req) begin
      resp_cnt <= $urandom_range(0, resp_max);
    end else if (resp_cnt == 0) begin
      resp_ack <= tx_req;
    end else begin
      resp_cnt <= resp_cnt - 1;
    end
  end

  // ---------------- scoreboard bookkeeping ----------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Round-robin rule: first valid index after the last winner, wrapping.
  function automatic int rr_pick(input logic [3:0] v, input int last);
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (v[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
    end
    return -1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clock);
    srst     = 1'b1;
    in_valid = '0;
    err_clr  = 1'b0;
    repeat (2) @(negedge clock);
    srst = 1'b0;
  endtask

  task automatic wait_ready(input string name, input int limit);
    bit ok = 0;
    for (int c = 0; c < limit; c++) begin
      @(negedge clock);
      if (in_ready != '0) begin
        ok = 1;
        break;
      end
    end
    check(name, 32'(ok), 32'd1);
  endtask

  task automatic wait_idle(input string name, input int limit);
    bit ok = 0;
    for (int c = 0; c < limit; c++) begin
      @(negedge clock);
      if (!busy) begin
        ok = 1;
        break;
      end
    end
    check(name, 32'(ok), 32'd1);
  endtask

  // ---------------- random-phase monitor / reference model ----------------
  logic [DATA_W-1:0]         exp_q[$];
  logic [NUM_REQ-1:0]        valid_at_edge;
  logic [NUM_REQ*DATA_W-1:0] data_at_edge;
  logic                      mon_en = 1'b0;
  logic [NUM_REQ-1:0]        prev_ready;
  logic                      prev_txreq;
  int                        model_last;
  int                        grants;
  int                        w;

  always @(posedge clock) begin
    valid_at_edge <= in_valid;
    data_at_edge  <= in_data;
  end

  always @(negedge clock) begin
    if (mon_en) begin
      if (in_ready != '0) begin
        w = rr_pick(valid_at_edge, model_last);
        check("rnd_winner", 32'(in_ready), (w < 0) ? 32'd0 : (32'd1 << w));
        check("rnd_no_b2b", 32'(prev_ready), 32'd0);
        if (w >= 0) begin
          check("rnd_grant_id", 32'(grant_id), 32'(w));
          exp_q.push_back(data_at_edge[w*DATA_W +: DATA_W]);
          model_last = w;
        end
        grants++;
      end
      if (tx_req && !prev_txreq) begin
        check("rnd_pending", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("rnd_tx_data", 32'(tx_data), 32'(exp_q.pop_front()));
      end
      prev_ready = in_ready;
      prev_txreq = tx_req;
    end
  end

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [3:0]  valid;
    logic [31:0] data;
    logic [3:0]  exp_ready;
    logic [1:0]  exp_gid;
    logic [7:0]  exp_data;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    srst = 1'b1; in_valid = '0; in_data = '0; err_clr = 1'b0;
    man_ack = 1'b0; auto_ack = 1'b0; resp_max = 3;
    prev_ready = '0; prev_txreq = 1'b0; model_last = NUM_REQ - 1; grants = 0;

    // Table rows assume round-robin state carries over from the row above.
    vecs[0] = '{4'b0001, 32'h443322A5, 4'b0001, 2'd0, 8'hA5};
    vecs[1] = '{4'b0001, 32'h4433223C, 4'b0001, 2'd0, 8'h3C};
    vecs[2] = '{4'b1111, 32'hD4C3B2A1, 4'b0010, 2'd1, 8'hB2};
    vecs[3] = '{4'b1001, 32'hD4C3B2A1, 4'b1000, 2'd3, 8'hD4};
    vecs[4] = '{4'b1001, 32'h0F0E0D0C, 4'b0001, 2'd0, 8'h0C};
    vecs[5] = '{4'b0100, 32'h0F0E0D0C, 4'b0100, 2'd2, 8'h0E};
    vecs[6] = '{4'b0011, 32'h99887766, 4'b0001, 2'd0, 8'h66};
    vecs[7] = '{4'b1010, 32'h99887766, 4'b0010, 2'd1, 8'h77};

    // ---- reset values ----
    repeat (3) @(negedge clock);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_tx_req", 32'(tx_req), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_timeout_err", 32'(timeout_err), 32'd0);
    check("rst_xfer_cnt", 32'(xfer_cnt), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd3);
    check("rst_state", 32'(state_dbg), 32'(IDLE));
    srst = 1'b0;

    // ---- table of single transfers ----
    auto_ack = 1'b1;
    foreach (vecs[i]) begin
      @(negedge clock);
      in_valid = vecs[i].valid;
      in_data  = vecs[i].data;
      wait_ready("tbl_ready_seen", 20);
      check("tbl_in_ready", 32'(in_ready), 32'(vecs[i].exp_ready));
      check("tbl_grant_id", 32'(grant_id), 32'(vecs[i].exp_gid));
      check("tbl_tx_data", 32'(tx_data), 32'(vecs[i].exp_data));
      check("tbl_req_late", 32'(tx_req), 32'd0);
      in_valid = '0;
      @(negedge clock);
      check("tbl_req_rise", 32'(tx_req), 32'd1);
      check("tbl_ready_pulse", 32'(in_ready), 32'd0);
      wait_idle("tbl_idle", 60);
      check("tbl_tx_data_held", 32'(tx_data), 32'(vecs[i].exp_data));
      check("tbl_xfer_cnt", 32'(xfer_cnt), 32'(i + 1));
    end

    // ---- all four valid continuously: order 0,1,2,3,0 ----
    do_reset();
    in_valid = 4'hF;
    in_data  = 32'h40302010;
    for (int g = 0; g < 5; g++) begin
      wait_ready("rr_ready_seen", 60);
      check("rr_order", 32'(in_ready), 32'd1 << (g % NUM_REQ));
      @(negedge clock);
      check("rr_no_b2b", 32'(in_ready), 32'd0);
    end
    in_valid = '0;
    wait_idle("rr_idle", 60);
    check("rr_xfer_cnt", 32'(xfer_cnt), 32'd5);

    // ---- random traffic against the reference model ----
    do_reset();
    model_last = NUM_REQ - 1;
    grants     = 0;
    prev_ready = '0;
    prev_txreq = 1'b0;
    exp_q.delete();
    mon_en = 1'b1;
    for (int c = 0; c < 800; c++) begin
      @(negedge clock);
      in_valid = 4'($urandom_range(0, 15));
      in_data  = $urandom;
    end
    in_valid = '0;
    wait_idle("rnd_idle", 60);
    repeat (2) @(negedge clock);
    mon_en = 1'b0;
    check("rnd_xfer_cnt", 32'(xfer_cnt), 32'(grants));
    check("rnd_queue_drained", 32'(exp_q.size()), 32'd0);
    check("rnd_liveness", 32'(grants >= 20), 32'd1);
    check("rnd_no_timeout", 32'(timeout_err), 32'd0);

    // ---- xfer_cnt wrap 0xFFFF -> 0x0000 ----
    do_reset();
    @(negedge clock);
    force dut.xfer_cnt_q = 16'hFFFF;
    @(negedge clock);
    release dut.xfer_cnt_q;
    @(negedge clock);
    check("wrap_preload", 32'(xfer_cnt), 32'hFFFF);
    in_valid = 4'b0100;
    in_data  = 32'h00C30000;
    wait_ready("wrap_ready_seen", 20);
    in_valid = '0;
    wait_idle("wrap_idle", 60);
    check("wrap_xfer_cnt", 32'(xfer_cnt), 32'h0000);

    // ---- ack never arrives: timeout after 15 cycles in REQ_HI ----
    auto_ack = 1'b0;
    man_ack  = 1'b0;
    do_reset();
    in_valid = 4'b0001;
    in_data  = 32'h0000005A;
    wait_ready("tmo_ready_seen", 20);
    in_valid = '0;
    repeat (14) @(negedge clock);
    check("tmo_not_yet", 32'(timeout_err), 32'd0);
    err_clr = 1'b1;   // coincides with the timeout edge
    @(negedge clock);
    check("tmo_set_wins", 32'(timeout_err), 32'd1);
    check("tmo_req_held", 32'(tx_req), 32'd1);
    @(negedge clock);
    check("tmo_cleared", 32'(timeout_err), 32'd0);
    err_clr = 1'b0;

    // ---- reset during ACK_WAIT_LO ----
    man_ack = 1'b1;
    begin
      bit ok = 0;
      for (int c = 0; c < 20; c++) begin
        @(negedge clock);
        if (!tx_req) begin
          ok = 1;
          break;
        end
      end
      check("mid_req_dropped", 32'(ok), 32'd1);
    end
    check("mid_busy_before", 32'(busy), 32'd1);
    srst = 1'b1;
    @(negedge clock);
    check("mid_tx_req", 32'(tx_req), 32'd0);
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_xfer_cnt", 32'(xfer_cnt), 32'd0);
    check("mid_grant_id", 32'(grant_id), 32'd3);
    check("mid_tx_data", 32'(tx_data), 32'd0);

    // ---- stale ack held across reset release ----
    @(negedge clock);
    srst = 1'b0;
    repeat (4) @(negedge clock);
    in_valid = 4'b0001;
    in_data  = 32'h00000077;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      check("stale_blocked", 32'(in_ready), 32'd0);
    end
    man_ack = 1'b0;
    @(negedge clock);
    check("stale_sync1", 32'(in_ready), 32'd0);
    @(negedge clock);
    check("stale_sync2", 32'(in_ready), 32'd0);
    @(negedge clock);
    check("stale_grant", 32'(in_ready), 32'd1);
    check("stale_tx_data", 32'(tx_data), 32'h77);
    in_valid = '0;
    auto_ack = 1'b1;
    wait_idle("stale_idle", 60);
    check("stale_xfer_cnt", 32'(xfer_cnt), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cdc_hs_arbiter.md
CDC_HS_ARBITER -- requirements
Module: cdc_hs_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of source-domain requesters (2..8).
REQ-002 Parameter DATA_W, default 8, payload width per requester.
REQ-003 Parameter STAGES, default 2, flip-flop stages on the ack synchronizer (minimum 2).
REQ-004 Parameter TIMEOUT, default 1023, number of cycles allowed per handshake phase before the error flag is raised.
REQ-005 The block SHALL have one clock; its reset is synchronous and active-high. Ports are listed below.
REQ-006 clock  in  1  single clock; all logic is on its rising edge.
REQ-007 srst  in  1  reset; synchronous, active-high.
REQ-008 in_valid  in  NUM_REQ  per-requester valid.
REQ-009 in_data  in  NUM_REQ*DATA_W  payloads; requester i occupies bits [i*DATA_W +: DATA_W].
REQ-010 in_ready  out  NUM_REQ  one-hot acceptance pulse.
REQ-011 tx_req  out  1  4-phase request to the destination domain.
REQ-012 tx_data  out  DATA_W  held payload toward the destination domain.
REQ-013 tx_ack_async  in  1  4-phase acknowledge from the destination domain; asynchronous.
REQ-014 busy  out  1  high whenever the FSM is not in IDLE.
REQ-015 grant_id  out  $clog2(NUM_REQ)  index of the last accepted requester.
REQ-016 err_clr  in  1  clears timeout_err.
REQ-017 timeout_err  out  1  sticky timeout flag.
REQ-018 xfer_cnt  out  16  count of completed transfers.

Function
REQ-019 tx_ack_async SHALL pass through a STAGES-deep synchronizer, giving ack_s, before any use; latency is STAGES cycles.
REQ-020 FSM states: IDLE, REQ_HI, ACK_WAIT_LO.
REQ-021 IDLE, when any in_valid bit is high: grant the winner, pulse in_ready[winner] for exactly one cycle, capture its payload into tx_data, load grant_id, and go to REQ_HI.
REQ-022 tx_req SHALL be registered and high exactly while in REQ_HI; it rises 1 cycle after the in_ready pulse.
REQ-023 REQ_HI: on ack_s==1, go to ACK_WAIT_LO, which drops tx_req on the next cycle.
REQ-024 ACK_WAIT_LO: on ack_s==0, increment xfer_cnt (wrapping 0xFFFF->0x0000) and return to IDLE.
REQ-025 In that return-to-IDLE cycle, no grant is issued; a new grant can occur at the earliest in the following cycle.
REQ-026 tx_data SHALL remain stable from capture until return to IDLE.
REQ-027 Arbitration SHALL be round-robin: search starts at index (grant_id+1) mod NUM_REQ; the last winner has lowest priority.
REQ-028 in_ready SHALL be 0 in all states other than the IDLE grant cycle.
REQ-029 in_valid SHALL be ignored outside IDLE.
REQ-030 A requester that drops in_valid before being granted SHALL lose its place without any error.
REQ-031 Phase timer: cleared on entry to REQ_HI and on entry to ACK_WAIT_LO; increments every cycle in those two states; saturates.
REQ-032 When the phase timer reaches TIMEOUT, timeout_err SHALL set; the FSM keeps waiting, with no abort of the 4-phase protocol.
REQ-033 err_clr clears timeout_err; if a timeout event and err_clr occur in the same cycle, set wins.
REQ-034 ack_s==1 in IDLE (stale ack) SHALL block new grants until ack_s==0.

Reset
REQ-035 On srst, all outputs SHALL be 0 on the next edge: tx_req, tx_data, in_ready, busy, timeout_err, xfer_cnt.
REQ-036 On srst, grant_id SHALL be NUM_REQ-1, so requester 0 has first priority.
REQ-037 On srst, the FSM SHALL go to IDLE and the synchronizer stages and phase timer SHALL clear.
REQ-038 srst asserted mid-transfer SHALL drop tx_req immediately and discard the held payload; xfer_cnt is not incremented.

Structure
REQ-039 The FSM state enum, and the xfer_cnt width constant, SHALL live in package cdc_pkg.
REQ-040 Round-robin selection SHALL be a sub-module, cdc_rr_arbiter: inputs are the request vector and the last grant; outputs are a one-hot grant and an index.
REQ-041 The ack synchronizer SHALL be inline, using the synchronous reset.

Verification
REQ-042 Single transfer: in_valid=0001, data 0xA5; ack rises 3 cycles after tx_req -> in_ready=0001 for 1 cycle; tx_req high; tx_data=0xA5; xfer_cnt=1.
REQ-043 All four requesters valid continuously -> grant order 0,1,2,3,0; no back-to-back grants.
REQ-044 Ack never arrives, TIMEOUT=15 -> timeout_err set 15 cycles after REQ_HI entry; tx_req stays 1; err_clr in the same cycle as the timeout -> flag stays 1.
REQ-045 srst during ACK_WAIT_LO -> next cycle tx_req=0, busy=0, xfer_cnt unchanged, grant_id=3.
REQ-046 Preload xfer_cnt to 0xFFFF via 65535 transfers (or force), then one more transfer -> 0x0000.
REQ-047 Stale ack high at release of srst -> no in_ready until ack_s=0.
